pc_fetch_sequencer: RTL and testbench

Owns the architectural fetch PC and sequences instruction fetch over a request/grant/response instruction-memory interface, with a single transaction outstanding. It arbitrates redirect sources from execute (jalr > jal > branch), traps misaligned targets to a fixed vector, and holds the fetched instruction while decode stalls. It sits between execute/hazard logic and the IF/ID boundary, replacing free-running PC+4 update with a handshake-aware controller.

---
 rtl/pc_fetch_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Purpose:
//   Owns the architectural fetch PC and drives instruction fetch over a
//   request/grant/response instruction-memory interface. Only one transaction
//   is ever outstanding. Redirects from execute (jalr > jal > branch) override
//   stall and normal sequencing. Misaligned redirect targets are diverted to a
//   fixed trap vector. The fetched instruction is held at the IF/ID boundary
//   while decode stalls.
//
// Ports:
//   clk            in   1   clock, rising edge
//   reset          in   1   asynchronous, active-high
//   stall          in   1   decode cannot accept if_* this cycle
//   branch_taken   in   1   branch redirect request
//   branch_target  in  32   branch destination
//   jal            in   1   jal redirect request
//   jal_target     in  32   jal destination
//   jalr           in   1   jalr redirect request
//   jalr_target    in  32   jalr destination
//   imem_req       out  1   fetch request valid (state == REQ)
//   imem_addr      out 32   fetch address (== pc)
//   imem_gnt       in   1   request accepted this cycle
//   imem_rvalid    in   1   response data valid
//   imem_rdata     in  32   response instruction
//   if_valid       out  1   if_pc / if_instr valid to decode
//   if_pc          out 32   PC of presented instruction
//   if_instr       out 32   presented instruction (NOP_INSTR when not valid)
//   pc             out 32   current fetch PC
//   misalign_trap  out  1   one-cycle pulse: selected redirect target misaligned
//   trap_addr      out 32   offending target, held until the next trap
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jal,
    input  logic [31:0] jal_target,
    input  logic        jalr,
    input  logic [31:0] jalr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] pc,
    output logic        misalign_trap,
    output logic [31:0] trap_addr
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q,    if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        trap_q,     trap_d;
    logic [31:0] trap_addr_q, trap_addr_d;
    // Set when the in-flight response belongs to a fetch that a redirect
    // has made stale; that response must be swallowed, not presented.
    logic        discard_q,  discard_d;

    logic        redir_active;
    logic [31:0] redir_target;
    logic        redir_misaligned;
    logic [31:0] redir_effective;
    logic        hold_present;

    // Sequential successor; 32-bit addition wraps FFFF_FFFC -> 0 naturally.
    function automatic logic [31:0] seq_next(input logic [31:0] cur);
        return cur + 32'd4;
    endfunction

    // Redirect source priority: jalr over jal over branch.
    function automatic logic [31:0] pick_target(
        input logic        sel_jalr,
        input logic [31:0] t_jalr,
        input logic        sel_jal,
        input logic [31:0] t_jal,
        input logic [31:0] t_branch
    );
        if (sel_jalr) begin
            return t_jalr;
        end else if (sel_jal) begin
            return t_jal;
        end
        return t_branch;
    endfunction

    // ---------------------------------------------------------------------
    // Redirect selection
    // ---------------------------------------------------------------------
    always_comb begin
        redir_active     = jalr | jal | branch_taken;
        redir_target     = pick_target(jalr, jalr_target, jal, jal_target, branch_target);
        redir_misaligned = redir_active && (redir_target[1:0] != 2'b00);
        redir_effective  = redir_misaligned ? TRAP_VEC : redir_target;
    end

    // An instruction that is presented and not consumed stays put.
    assign hold_present = if_valid_q && stall;

    // ---------------------------------------------------------------------
    // Next-state / next-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        trap_d      = 1'b0;
        trap_addr_d = trap_addr_q;
        if_pc_d     = if_pc_q;
        if (hold_present) begin
            if_valid_d = 1'b1;
            if_instr_d = if_instr_q;
        end else begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end

        if (redir_active) begin
            // Redirect wins over stall and over normal sequencing; anything
            // presented to decode belongs to the wrong path and is flushed.
            pc_d       = redir_effective;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            if (redir_misaligned) begin
                trap_d      = 1'b1;
                trap_addr_d = redir_target;
            end
            case (state_q)
                BOOT: state_d = REQ;
                REQ: begin
                    // A grant on this edge commits the old request; its
                    // response is still coming and must be dropped.
                    if (imem_gnt) begin
                        state_d   = WAIT;
                        discard_d = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d   = REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                HOLD: state_d = REQ;
                default: state_d = BOOT;
            endcase
        end else begin
            case (state_q)
                BOOT: state_d = REQ;
                REQ: begin
                    if (imem_gnt) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            // Stale response: pc already points at the
                            // redirect target, so no increment here.
                            discard_d = 1'b0;
                            state_d   = REQ;
                        end else begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_instr_d = imem_rdata;
                            pc_d       = seq_next(pc_q);
                            state_d    = stall ? HOLD : REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_d = REQ;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_pc_q     <= 32'h0000_0000;
            if_instr_q  <= NOP_INSTR;
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0000_0000;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
            discard_q   <= discard_d;
        end
    end

    // Request is a pure decode of state so it drops the moment the
    // sequencer leaves REQ; this guarantees a single outstanding fetch.
    assign imem_req      = (state_q == REQ);
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign if_valid      = if_valid_q;
    assign if_pc         = if_pc_q;
    assign if_instr      = if_instr_q;
    assign misalign_trap = trap_q;
    assign trap_addr     = trap_addr_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jal;
    logic [31:0] jal_target;
    logic        jalr;
    logic [31:0] jalr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] pc;
    logic        misalign_trap;
    logic [31:0] trap_addr;

    pc_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jal           (jal),
        .jal_target    (jal_target),
        .jalr          (jalr),
        .jalr_target   (jalr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .pc            (pc),
        .misalign_trap (misalign_trap),
        .trap_addr     (trap_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    item_t       sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    bit          got_new;
    bit          prev_valid;
    bit          pend;
    logic [31:0] paddr;
    int          cnt;
    int          lat;

    function automatic void push_exp(input logic [31:0] a);
        item_t it;
        it.pc    = a;
        it.instr = a ^ K;
        sb_q.push_back(it);
    endfunction

    // One clock: sample at negedge, score new presentations, run memory model.
    task automatic step();
        item_t e;
        @(negedge clk);
        got_new = 1'b0;
        if (if_valid && !(prev_valid && stall)) begin
            got_new = 1'b1;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_item: got if_pc=%h if_instr=%h, none expected", if_pc, if_instr);
            end else begin
                e = sb_q.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr) begin
                    errors++;
                    $display("FAIL sb_item: got pc=%h instr=%h expected pc=%h instr=%h",
                             if_pc, if_instr, e.pc, e.instr);
                end
            end
        end
        prev_valid  = if_valid;
        imem_rvalid = 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = paddr ^ K;
                pend        = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (imem_req && imem_gnt) begin
            pend  = 1'b1;
            paddr = imem_addr;
            cnt   = lat - 1;
        end
        cyc++;
    endtask

    task automatic reset_dut();
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jal           = 1'b0;
        jal_target    = 32'h0;
        jalr          = 1'b0;
        jalr_target   = 32'h0;
        imem_gnt      = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        pend          = 1'b0;
        lat           = 1;
        prev_valid    = 1'b0;
        sb_q.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        reset = 1'b1;
        step();
        checks++; if (pc !== 32'h0)        begin errors++; $display("FAIL rst_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
        checks++; if (if_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
        checks++; if (if_pc !== 32'h0)     begin errors++; $display("FAIL rst_if_pc: got %h expected 0", if_pc); end
        checks++; if (if_instr !== NOP)    begin errors++; $display("FAIL rst_if_instr: got %h expected %h", if_instr, NOP); end
        checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL rst_trap: got %b expected 0", misalign_trap); end
        checks++; if (trap_addr !== 32'h0) begin errors++; $display("FAIL rst_trap_addr: got %h expected 0", trap_addr); end
        reset = 1'b0;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL boot_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [4];
        int k;
        int last_new;
        exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8; exp_addr[3] = 32'hC;
        reset_dut();
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        k = 0;
        last_new = -1;
        for (int i = 0; i < 40 && k < 4; i++) begin
            step();
            if (got_new) begin
                if (last_new >= 0) begin
                    checks++;
                    if (cyc - last_new != 2) begin
                        errors++;
                        $display("FAIL seq_gap: got %0d cycles expected 2", cyc - last_new);
                    end
                end
                last_new = cyc;
            end
            if (imem_req) begin
                checks++;
                if (imem_addr !== exp_addr[k]) begin
                    errors++;
                    $display("FAIL seq_addr%0d: got %h expected %h", k, imem_addr, exp_addr[k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 4 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL seq_done: got reqs=%0d pending=%0d expected reqs=4 pending=0", k, sb_q.size());
        end
    endtask

    task automatic test_stall();
        bit found;
        reset_dut();
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (imem_req && imem_addr == 32'h4) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL stall_setup: got no request for 4, expected one"); end
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== (32'h4 ^ K)) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h expected v=1 pc=4 instr=%h",
                         i, if_valid, if_pc, if_instr, 32'h4 ^ K);
            end
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_req%0d: got %b expected 0", i, imem_req);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got req=%b addr=%h v=%b expected req=1 addr=8 v=0",
                     imem_req, imem_addr, if_valid);
        end
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d pending expected 0", sb_q.size()); end
    endtask

    task automatic test_jal_flush();
        reset_dut();
        lat = 3;
        push_exp(32'h40);
        step();
        step();
        jal = 1'b1;
        jal_target = 32'h40;
        step();
        jal = 1'b0;
        lat = 1;
        checks++;
        if (pc !== 32'h40 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL jal_redirect: got pc=%h req=%b v=%b expected pc=40 req=0 v=0", pc, imem_req, if_valid);
        end
        for (int i = 0; i < 20 && !imem_req; i++) step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL jal_addr: got req=%b addr=%h expected req=1 addr=40", imem_req, imem_addr);
        end
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL jal_drain: got %0d pending expected 0", sb_q.size()); end
    endtask

    task automatic test_priority();
        reset_dut();
        push_exp(32'h80);
        step();
        jalr = 1'b1; jalr_target = 32'h80;
        branch_taken = 1'b1; branch_target = 32'h20;
        step();
        jalr = 1'b0; branch_taken = 1'b0;
        checks++;
        if (pc !== 32'h80) begin errors++; $display("FAIL prio_pc: got %h expected 80", pc); end
        for (int i = 0; i < 20 && !imem_req; i++) step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            errors++;
            $display("FAIL prio_addr: got req=%b addr=%h expected req=1 addr=80", imem_req, imem_addr);
        end
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL prio_drain: got %0d pending expected 0", sb_q.size()); end
    endtask

    task automatic test_misalign();
        reset_dut();
        push_exp(32'h100);
        step();
        branch_taken = 1'b1; branch_target = 32'h102;
        step();
        branch_taken = 1'b0;
        checks++;
        if (misalign_trap !== 1'b1 || trap_addr !== 32'h102 || pc !== 32'h100) begin
            errors++;
            $display("FAIL mis_trap: got trap=%b taddr=%h pc=%h expected trap=1 taddr=102 pc=100",
                     misalign_trap, trap_addr, pc);
        end
        step();
        checks++;
        if (misalign_trap !== 1'b0 || trap_addr !== 32'h102) begin
            errors++;
            $display("FAIL mis_pulse: got trap=%b taddr=%h expected trap=0 taddr=102", misalign_trap, trap_addr);
        end
        for (int i = 0; i < 20 && !imem_req; i++) step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL mis_addr: got req=%b addr=%h expected req=1 addr=100", imem_req, imem_addr);
        end
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL mis_drain: got %0d pending expected 0", sb_q.size()); end
    endtask

    task automatic test_wrap_and_async_reset();
        reset_dut();
        push_exp(32'hFFFF_FFFC); push_exp(32'h0);
        step();
        jal = 1'b1; jal_target = 32'hFFFF_FFFC;
        step();
        jal = 1'b0;
        checks++;
        if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_set: got %h expected FFFFFFFC", pc); end
        for (int i = 0; i < 20 && !imem_req; i++) step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=FFFFFFFC", imem_req, imem_addr);
        end
        step();
        step();
        checks++;
        if (pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: got pc=%h req=%b addr=%h expected pc=0 req=1 addr=0", pc, imem_req, imem_addr);
        end
        step();
        step();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d pending expected 0", sb_q.size()); end
        // Keep the instruction at 0 presented while the fetch of 4 is in WAIT.
        stall = 1'b1;
        step();
        checks++;
        if (pc !== 32'h4 || if_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL areset_pre: got pc=%h v=%b req=%b expected pc=4 v=1 req=0", pc, if_valid, imem_req);
        end
        #2;
        reset = 1'b1;
        stall = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || if_valid !== 1'b0 || if_instr !== NOP) begin
            errors++;
            $display("FAIL areset: got pc=%h req=%b v=%b instr=%h expected pc=0 req=0 v=0 instr=%h",
                     pc, imem_req, if_valid, if_instr, NOP);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jal_flush();
        test_priority();
        test_misalign();
        test_wrap_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
